// File: rtl/snake_game_ctrl_if.sv
// Bundle of game-side signals for snake_game_ctrl.
//   master: drives tick, direction, apple_*, fb_row_sel; observes fb_row and status.
//   slave : the game controller.
//   tick        move strobe          direction  up/down/left/right buttons [3:0]
//   apple_*     apple present / col / row
//   fb_row_sel  scanner row select   fb_row     active-low row data, bit n = column n
//   apple_eaten / length / busy / game_over    status back to the game shell
interface snake_game_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic          tick;
    logic [3:0]    direction;
    logic          apple_valid;
    logic [2:0]    apple_x;
    logic [2:0]    apple_y;
    logic [2:0]    fb_row_sel;
    logic [7:0]    fb_row;
    logic          apple_eaten;
    logic [LW-1:0] length;
    logic          busy;
    logic          game_over;

    modport master (
        output tick, direction, apple_valid, apple_x, apple_y, fb_row_sel,
        input  fb_row, apple_eaten, length, busy, game_over
    );

    modport slave (
        input  tick, direction, apple_valid, apple_x, apple_y, fb_row_sel,
        output fb_row, apple_eaten, length, busy, game_over
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the 8x8 LED snake.
// Each accepted move tick runs RUN -> CALC -> COMMIT -> RUN: CALC works out the
// next head, apple hit and self-collision; COMMIT pushes the head into the body
// FIFO, pops the tail unless growing, and updates the occupancy bitmap.
// Ports:
//   clk    system clock
//   clear  synchronous active-high reset
//   sif    snake_game_ctrl_if.slave (tick, direction, apple, scanner, status)
module snake_game_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic               clk,
    input  logic               clear,
    snake_game_ctrl_if.slave   sif
);
    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    // Direction codes; a reverse pair differs only in bit 0.
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_RUN, S_CALC, S_COMMIT, S_OVER} state_t;

    state_t        state, state_nxt;
    logic [1:0]    dir, moved_dir, calc_dir;
    logic [5:0]    body [MAX_LEN];        // {y,x}
    logic [PW-1:0] hd_ptr, tl_ptr;
    logic [7:0]    occ [8];               // occ[y][x]
    logic [LW-1:0] len;

    // Move result captured in CALC, applied in COMMIT.
    logic [2:0]    nx_q, ny_q;
    logic          hit_q, grow_q;

    logic [5:0]    head, tail;
    logic [2:0]    nx, ny;
    logic          hit, grow, coll;
    logic [1:0]    req;
    logic          req_vld;

    assign head = body[hd_ptr];
    assign tail = body[tl_ptr];

    // Next head; 3-bit arithmetic gives the mod-8 wrap for free.
    always_comb begin
        nx = head[2:0];
        ny = head[5:3];
        case (dir)
            D_UP:    ny = head[5:3] - 3'd1;
            D_DOWN:  ny = head[5:3] + 3'd1;
            D_LEFT:  nx = head[2:0] - 3'd1;
            default: nx = head[2:0] + 3'd1;
        endcase
    end

    assign hit  = sif.apple_valid && (nx == sif.apple_x) && (ny == sif.apple_y);
    assign grow = hit && (len < LW'(MAX_LEN));
    // Stepping onto the tail is safe when the tail is about to leave.
    assign coll = occ[ny][nx] && !(({ny, nx} == tail) && !grow);

    // Button priority up > down > left > right.
    always_comb begin
        req     = dir;
        req_vld = 1'b1;
        if      (sif.direction[3]) req = D_UP;
        else if (sif.direction[2]) req = D_DOWN;
        else if (sif.direction[1]) req = D_LEFT;
        else if (sif.direction[0]) req = D_RIGHT;
        else                       req_vld = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (sif.tick) state_nxt = S_CALC;
            S_CALC:   state_nxt = coll ? S_OVER : S_COMMIT;
            S_COMMIT: state_nxt = S_RUN;
            default:  state_nxt = S_OVER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_RUN;
            dir       <= D_RIGHT;
            moved_dir <= D_RIGHT;
            calc_dir  <= D_RIGHT;
            hd_ptr    <= PW'(INIT_LEN - 1);
            tl_ptr    <= '0;
            len       <= LW'(INIT_LEN);
            nx_q      <= '0;
            ny_q      <= '0;
            hit_q     <= 1'b0;
            grow_q    <= 1'b0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    occ[r][c] <= (r == 0) && (c < INIT_LEN);
            for (int i = 0; i < INIT_LEN; i++)
                body[i] <= {3'd0, 3'(i)};
        end else begin
            state <= state_nxt;
            // Reversal is judged against the direction actually moved, so
            // two quick presses cannot fold the snake onto its neck.
            if (req_vld && ((req ^ 2'b01) != moved_dir))
                dir <= req;
            case (state)
                S_CALC: begin
                    nx_q     <= nx;
                    ny_q     <= ny;
                    hit_q    <= hit;
                    grow_q   <= grow;
                    calc_dir <= dir;
                end
                S_COMMIT: begin
                    if (!grow_q) begin
                        occ[tail[5:3]][tail[2:0]] <= 1'b0;
                        tl_ptr <= tl_ptr + 1'b1;
                    end
                    // Set after clear: last NBA wins when the head lands on the old tail.
                    occ[ny_q][nx_q]      <= 1'b1;
                    body[hd_ptr + 1'b1]  <= {ny_q, nx_q};
                    hd_ptr               <= hd_ptr + 1'b1;
                    if (grow_q) len <= len + 1'b1;
                    moved_dir <= calc_dir;
                end
                default: ;
            endcase
        end
    end

    assign sif.fb_row      = ~occ[sif.fb_row_sel];
    assign sif.apple_eaten = (state == S_COMMIT) && hit_q;
    assign sif.length      = len;
    assign sif.busy        = (state == S_CALC) || (state == S_COMMIT);
    assign sif.game_over   = (state == S_OVER);
endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    snake_game_ctrl_if #(.MAX_LEN(MAX_LEN)) sif();

    snake_game_ctrl #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk   (clk),
        .clear (clear),
        .sif   (sif)
    );

    int checks = 0;
    int passes = 0;

    // Model: snake as coordinate queues, tail at index 0.
    int qx[$];
    int qy[$];
    int dir_m, moved_m, exp_len;
    bit exp_busy, exp_eaten, exp_over;
    bit model_ok = 1'b0;

    function automatic logic [7:0] model_row(int r);
        logic [7:0] v = 8'hFF;
        foreach (qx[i]) if (qy[i] == r) v[qx[i]] = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("length",      int'(sif.length),      exp_len);
            chk("busy",        int'(sif.busy),        int'(exp_busy));
            chk("game_over",   int'(sif.game_over),   int'(exp_over));
            chk("apple_eaten", int'(sif.apple_eaten), int'(exp_eaten));
            chk("fb_row",      int'(sif.fb_row),      int'(model_row(int'(sif.fb_row_sel))));
        end
    end

    // Every stimulus step ends 1 time unit after a rising edge; rows rotate each cycle.
    task automatic step();
        @(posedge clk);
        #1;
        sif.fb_row_sel = 3'(sif.fb_row_sel + 3'd1);
    endtask

    task automatic model_reset();
        qx.delete();
        qy.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            qx.push_back(i);
            qy.push_back(0);
        end
        dir_m = 3; moved_m = 3; exp_len = INIT_LEN;
        exp_busy = 0; exp_eaten = 0; exp_over = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        model_ok = 1'b1;
    endtask

    // codes: 0 up, 1 down, 2 left, 3 right
    task automatic set_dir(input logic [3:0] d);
        int r;
        sif.direction = d;
        step();
        sif.direction = 4'd0;
        r = d[3] ? 0 : d[2] ? 1 : d[1] ? 2 : d[0] ? 3 : -1;
        if (r >= 0 && (r ^ 1) != moved_m) dir_m = r;
    endtask

    task automatic set_apple(input bit v, input int x, input int y);
        sif.apple_valid = v;
        sif.apple_x = 3'(x);
        sif.apple_y = 3'(y);
    endtask

    task automatic do_tick(input bit hold2, input bit abort);
        int nx, ny, dx, dy;
        bit hit, grow, coll;
        sif.tick = 1'b1;
        step();
        if (!hold2) sif.tick = 1'b0;
        if (exp_over) begin
            sif.tick = 1'b0;
            return;
        end
        dx = 0; dy = 0;
        case (dir_m)
            0: dy = -1;
            1: dy = 1;
            2: dx = -1;
            default: dx = 1;
        endcase
        nx = (qx[qx.size()-1] + dx + 8) % 8;
        ny = (qy[qy.size()-1] + dy + 8) % 8;
        hit  = sif.apple_valid && nx == int'(sif.apple_x) && ny == int'(sif.apple_y);
        grow = hit && exp_len < MAX_LEN;
        coll = 0;
        foreach (qx[i])
            if (qx[i] == nx && qy[i] == ny && !(i == 0 && !grow)) coll = 1;
        exp_busy = 1; exp_eaten = 0;
        step();
        sif.tick = 1'b0;
        if (coll) begin
            exp_busy = 0;
            exp_over = 1;
            return;
        end
        exp_eaten = hit;
        if (abort) begin
            clear = 1'b1;
            step();
            clear = 1'b0;
            model_reset();
            return;
        end
        step();
        qx.push_back(nx);
        qy.push_back(ny);
        if (grow) exp_len++;
        else begin
            void'(qx.pop_front());
            void'(qy.pop_front());
        end
        moved_m = dir_m;
        exp_busy = 0; exp_eaten = 0;
    endtask

    task automatic pin_row(input string name, input int r, input logic [7:0] exp);
        sif.fb_row_sel = 3'(r);
        #1;
        chk(name, int'(sif.fb_row), int'(exp));
    endtask

    initial begin
        sif.tick = 1'b0;
        sif.direction = 4'd0;
        sif.fb_row_sel = 3'd0;
        set_apple(0, 0, 0);

        // reset
        do_clear();
        pin_row("rst_row0", 0, 8'b11111000);
        pin_row("rst_row5", 5, 8'hFF);
        chk("rst_len",  int'(sif.length), 3);
        chk("rst_over", int'(sif.game_over), 0);
        chk("rst_busy", int'(sif.busy), 0);

        // wrap around the right edge: body ends at (6,0),(7,0),(0,0)
        repeat (6) do_tick(0, 0);
        pin_row("wrap_row0", 0, 8'b00111110);
        chk("wrap_over", int'(sif.game_over), 0);

        // reverse request ignored
        do_clear();
        set_dir(4'b0010);
        do_tick(0, 0);
        pin_row("rev_row0", 0, 8'b11110001);
        do_tick(0, 0);
        pin_row("rev_row0b", 0, 8'b11100011);

        // grow twice, then run into own body
        do_clear();
        set_apple(1, 3, 0);
        do_tick(0, 0);
        chk("grow_len4", int'(sif.length), 4);
        set_apple(1, 4, 0);
        do_tick(0, 0);
        set_apple(0, 0, 0);
        chk("grow_len5", int'(sif.length), 5);
        set_dir(4'b0100); do_tick(0, 0);
        set_dir(4'b0010); do_tick(0, 0);
        set_dir(4'b1000); do_tick(0, 0);
        chk("coll_over", int'(sif.game_over), 1);
        chk("coll_len",  int'(sif.length), 5);
        pin_row("coll_row0", 0, 8'hE3);
        pin_row("coll_row1", 1, 8'hE7);
        do_tick(0, 0);
        repeat (3) step();
        pin_row("over_row0", 0, 8'hE3);

        // tail chase on a 2x2 square
        do_clear();
        set_apple(1, 3, 0);
        do_tick(0, 0);
        set_apple(0, 0, 0);
        repeat (2) begin
            set_dir(4'b0001); do_tick(0, 0);
            set_dir(4'b0100); do_tick(0, 0);
            set_dir(4'b0010); do_tick(0, 0);
            set_dir(4'b1000); do_tick(0, 0);
        end
        chk("chase_over", int'(sif.game_over), 0);
        chk("chase_len",  int'(sif.length), 4);
        pin_row("chase_row0", 0, 8'hE7);
        pin_row("chase_row1", 1, 8'hE7);

        // tick held two cycles moves once; clear during COMMIT aborts the move
        do_clear();
        do_tick(1, 0);
        pin_row("dbl_row0", 0, 8'b11110001);
        set_apple(1, 4, 0);
        do_tick(0, 1);
        set_apple(0, 0, 0);
        pin_row("abort_row0", 0, 8'b11111000);
        chk("abort_eaten", int'(sif.apple_eaten), 0);
        chk("abort_len",   int'(sif.length), 3);
        repeat (4) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
